// File: rtl/display_capture.sv
// Display-bus monitor: debounces {D, Digit, DP}, tracks the Digit1..Digit4 scan order,
// range-checks each digit and republishes the last good HH:MM frame with sticky error flags.
module display_capture #(
  parameter int STABLE = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] D,
  input  logic [3:0] Digit,
  input  logic       DP,
  input  logic       ClearErr,
  output logic [3:0] HourTens,
  output logic [3:0] HourUnits,
  output logic [3:0] MinTens,
  output logic [3:0] MinUnits,
  output logic [3:0] DpMask,
  output logic       FrameValid,
  output logic       DigitErr,
  output logic       OrderErr,
  output logic       RangeErr
);

  localparam logic [3:0] CNT_MAX = 4'(STABLE - 1);

  typedef enum logic [1:0] {HUNT, EXP2, EXP3, EXP4} state_t;

  // pos 0..3 = hour tens, hour units, minute tens, minute units
  function automatic logic digit_out_of_range(input logic [1:0] pos, input logic [3:0] d,
                                              input logic [3:0] hour_tens);
    logic bad;
    bad = (d > 4'd9);
    case (pos)
      2'd0:    bad = bad | (d > 4'd2);
      2'd1:    bad = bad | ({hour_tens, d} > 8'h23);
      2'd2:    bad = bad | (d > 4'd5);
      default: bad = bad;
    endcase
    return bad;
  endfunction

  logic [8:0] bus_in, s_bus_q, s_bus_d;
  logic       bus_changed;
  logic [3:0] cnt_q, cnt_d;
  logic       accepted_q, accepted_d, accept;
  state_t     state_q, state_d;

  logic [3:0] s_d, s_digit;
  logic       s_dp, is_onehot;
  logic [1:0] pos;
  logic       store, complete, range_fail;
  logic       new_digit_err, new_order_err, new_range_err;

  logic [3:0] sh_ht_q, sh_ht_d, sh_hu_q, sh_hu_d, sh_mt_q, sh_mt_d;
  logic [2:0] sh_dp_q, sh_dp_d;
  logic       bad_q, bad_d;

  logic [3:0] ht_q, ht_d, hu_q, hu_d, mt_q, mt_d, mu_q, mu_d, dpm_q, dpm_d;
  logic       fv_q, fv_d;
  logic       digit_err_q, digit_err_d, order_err_q, order_err_d, range_err_q, range_err_d;

  always_comb begin
    // Stage 0 capture and stability tracking
    bus_in      = {D, Digit, DP};
    bus_changed = (bus_in != s_bus_q);
    s_bus_d     = bus_in;
    cnt_d       = bus_changed ? 4'd0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1);
    accept      = (cnt_q == CNT_MAX) && !accepted_q;
    accepted_d  = !bus_changed && (accepted_q || accept);

    s_d       = s_bus_q[8:5];
    s_digit   = s_bus_q[4:1];
    s_dp      = s_bus_q[0];
    is_onehot = (s_digit != 4'd0) && ((s_digit & (s_digit - 4'd1)) == 4'd0);
    case (s_digit)
      4'b1000: pos = 2'd0;
      4'b0100: pos = 2'd1;
      4'b0010: pos = 2'd2;
      default: pos = 2'd3;
    endcase

    store         = 1'b0;
    complete      = 1'b0;
    range_fail    = 1'b0;
    new_digit_err = 1'b0;
    new_order_err = 1'b0;
    new_range_err = 1'b0;
    state_d       = state_q;
    sh_ht_d       = sh_ht_q;
    sh_hu_d       = sh_hu_q;
    sh_mt_d       = sh_mt_q;
    sh_dp_d       = sh_dp_q;
    bad_d         = bad_q;
    ht_d          = ht_q;
    hu_d          = hu_q;
    mt_d          = mt_q;
    mu_d          = mu_q;
    dpm_d         = dpm_q;
    fv_d          = 1'b0;

    // Stage 1 sequencing on an accepted strobe
    if (accept && (s_digit != 4'd0)) begin
      if (!is_onehot) begin
        new_digit_err = 1'b1;
        state_d       = HUNT;
      end else if (pos == 2'(state_q)) begin
        store    = 1'b1;
        complete = (state_q == EXP4);
        state_d  = state_t'(2'(state_q) + 2'd1);
      end else if (state_q != HUNT) begin
        new_order_err = 1'b1;
        store         = (pos == 2'd0);
        state_d       = (pos == 2'd0) ? EXP2 : HUNT;
      end
    end

    if (store) begin
      range_fail    = digit_out_of_range(pos, s_d, sh_ht_q);
      new_range_err = range_fail;
      case (pos)
        2'd0: begin sh_ht_d = s_d; sh_dp_d[2] = s_dp; bad_d = range_fail; end
        2'd1: begin sh_hu_d = s_d; sh_dp_d[1] = s_dp; bad_d = bad_q | range_fail; end
        2'd2: begin sh_mt_d = s_d; sh_dp_d[0] = s_dp; bad_d = bad_q | range_fail; end
        default: bad_d = bad_q | range_fail;
      endcase
    end

    // Minute units come straight from the bus so the frame lands on the Digit4 store edge
    if (complete && !(bad_q || range_fail)) begin
      ht_d  = sh_ht_q;
      hu_d  = sh_hu_q;
      mt_d  = sh_mt_q;
      mu_d  = s_d;
      dpm_d = {sh_dp_q, s_dp};
      fv_d  = 1'b1;
    end

    digit_err_d = new_digit_err | (digit_err_q & ~ClearErr);
    order_err_d = new_order_err | (order_err_q & ~ClearErr);
    range_err_d = new_range_err | (range_err_q & ~ClearErr);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s_bus_q     <= '0;
      cnt_q       <= '0;
      accepted_q  <= 1'b0;
      state_q     <= HUNT;
      ht_q        <= '0;
      hu_q        <= '0;
      mt_q        <= '0;
      mu_q        <= '0;
      dpm_q       <= '0;
      fv_q        <= 1'b0;
      digit_err_q <= 1'b0;
      order_err_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      s_bus_q     <= s_bus_d;
      cnt_q       <= cnt_d;
      accepted_q  <= accepted_d;
      state_q     <= state_d;
      ht_q        <= ht_d;
      hu_q        <= hu_d;
      mt_q        <= mt_d;
      mu_q        <= mu_d;
      dpm_q       <= dpm_d;
      fv_q        <= fv_d;
      digit_err_q <= digit_err_d;
      order_err_q <= order_err_d;
      range_err_q <= range_err_d;
    end
  end

  // Shadow frame needs no reset: a frame can only start with a Digit1 store from HUNT
  always_ff @(posedge Clock) begin
    sh_ht_q <= sh_ht_d;
    sh_hu_q <= sh_hu_d;
    sh_mt_q <= sh_mt_d;
    sh_dp_q <= sh_dp_d;
    bad_q   <= bad_d;
  end

  assign HourTens   = ht_q;
  assign HourUnits  = hu_q;
  assign MinTens    = mt_q;
  assign MinUnits   = mu_q;
  assign DpMask     = dpm_q;
  assign FrameValid = fv_q;
  assign DigitErr   = digit_err_q;
  assign OrderErr   = order_err_q;
  assign RangeErr   = range_err_q;

endmodule
